// File: rtl/hyperbus_delay_cfg_pkg.sv
// Shared types and defaults for the hyperbus delay-line configuration sequencer.
package hyperbus_delay_cfg_pkg;

   localparam int unsigned DelayWidthDefault = 32'd4;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      DRAIN  = 3'd1,
      UPDATE = 3'd2,
      SETTLE = 3'd3,
      UNGATE = 3'd4
   } delay_seq_state_e;

endpackage

// File: rtl/hyperbus_delay_settle_cnt.sv
// Loadable down-counter that times both the drain and the settle waits.
// It holds at zero until it is loaded again.
module hyperbus_delay_settle_cnt
   import hyperbus_delay_cfg_pkg::*;
#(
   parameter int unsigned CntWidth = 32'd3
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                load_i,
   input  logic [CntWidth-1:0] load_val_i,
   output logic                zero_o
);

   logic [CntWidth-1:0] cnt_q, cnt_d;

   // next count: load wins, otherwise count down and stop at zero
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CntWidth'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // count register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/hyperbus_delay_cfg_seq.sv
// Glitch-free delay-code sequencer for one hyperbus clock-delay line: gate, drain, update, settle, ungate.
// Optional build macro HYPERBUS_DELAY_RAMP_EN steps the code one LSB per update instead of jumping.
module hyperbus_delay_cfg_seq
   import hyperbus_delay_cfg_pkg::*;
#(
   parameter int unsigned DelayWidth   = DelayWidthDefault,
   parameter int unsigned SettleCycles = 32'd4,
   parameter int unsigned ResetDelay   = 32'd0
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  phy_clk_en_i,
   input  logic                  req_valid_i,
   input  logic [DelayWidth-1:0] req_delay_i,
   output logic                  req_ready_o,
   output logic                  done_o,
   output logic                  busy_o,
   output logic [DelayWidth-1:0] delay_o,
   output logic                  enable_o
);

   localparam int unsigned CntWidth = $clog2(SettleCycles + 32'd1);
   localparam logic [CntWidth-1:0]   CntLoad   = CntWidth'(SettleCycles - 32'd1);
   localparam logic [DelayWidth-1:0] ResetCode = DelayWidth'(ResetDelay);

   delay_seq_state_e      state_q, state_d;
   logic [DelayWidth-1:0] delay_q, delay_d;
   logic [DelayWidth-1:0] target_q, target_d;
   logic                  gate_q, gate_d;
   logic                  done_q, done_d;
   logic                  cnt_load_s;
   logic                  cnt_zero_s;

   hyperbus_delay_settle_cnt #(
      .CntWidth (CntWidth)
   ) u_settle_cnt (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .load_i     (cnt_load_s),
      .load_val_i (CntLoad),
      .zero_o     (cnt_zero_s)
   );

   // sequencing: delay_d may only differ from delay_q in UPDATE, where gate_q is always set
   always_comb begin
      state_d    = state_q;
      delay_d    = delay_q;
      target_d   = target_q;
      gate_d     = gate_q;
      done_d     = 1'b0;
      cnt_load_s = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_valid_i) begin
               target_d = req_delay_i;
               if (req_delay_i == delay_q) begin
                  done_d = 1'b1;
               end else begin
                  gate_d     = 1'b1;
                  cnt_load_s = 1'b1;
                  state_d    = DRAIN;
               end
            end else begin
               state_d = IDLE;
            end
         end
         DRAIN: begin
            if (cnt_zero_s) begin
               state_d = UPDATE;
            end else begin
               state_d = DRAIN;
            end
         end
         UPDATE: begin
`ifdef HYPERBUS_DELAY_RAMP_EN
            if (target_q > delay_q) begin
               delay_d = delay_q + DelayWidth'(1);
            end else if (target_q < delay_q) begin
               delay_d = delay_q - DelayWidth'(1);
            end else begin
               delay_d = delay_q;
            end
`else
            delay_d = target_q;
`endif
            cnt_load_s = 1'b1;
            state_d    = SETTLE;
         end
         SETTLE: begin
            if (cnt_zero_s) begin
`ifdef HYPERBUS_DELAY_RAMP_EN
               if (delay_q != target_q) begin
                  state_d = UPDATE;
               end else begin
                  gate_d  = 1'b0;
                  state_d = UNGATE;
               end
`else
               gate_d  = 1'b0;
               state_d = UNGATE;
`endif
            end else begin
               state_d = SETTLE;
            end
         end
         UNGATE: begin
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: begin
            gate_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   // state and datapath registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         delay_q  <= ResetCode;
         target_q <= ResetCode;
         gate_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         delay_q  <= delay_d;
         target_q <= target_d;
         gate_q   <= gate_d;
         done_q   <= done_d;
      end
   end

   assign req_ready_o = (state_q == IDLE);
   assign busy_o      = (state_q != IDLE);
   assign done_o      = done_q;
   assign delay_o     = delay_q;
   assign enable_o    = phy_clk_en_i & ~gate_q;

endmodule

// File: tb/tb_hyperbus_delay_cfg_seq.sv
// Scoreboard bench for hyperbus_delay_cfg_seq: a request driver feeds an expectation queue and a
// timing-window model; a negedge monitor compares every cycle and on each done_o pulse.
module tb_hyperbus_delay_cfg_seq;

   localparam int DW = 4;
   localparam int S  = 4;
   localparam int RD = 0;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          phy_en;
   logic          req_valid;
   logic [DW-1:0] req_delay;
   logic          req_ready;
   logic          done;
   logic          busy;
   logic [DW-1:0] delay;
   logic          enable;

   always #5 clk = ~clk;

   hyperbus_delay_cfg_seq #(
      .DelayWidth   (DW),
      .SettleCycles (S),
      .ResetDelay   (RD)
   ) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .phy_clk_en_i (phy_en),
      .req_valid_i  (req_valid),
      .req_delay_i  (req_delay),
      .req_ready_o  (req_ready),
      .done_o       (done),
      .busy_o       (busy),
      .delay_o      (delay),
      .enable_o     (enable)
   );

   typedef struct {
      int code;
      int due;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;
   int   cur;
   int   win_acc, win_old, win_new, win_len;
   bit   win_chg;
   bit   mon_en = 1'b0;
   bit   phy_rand = 1'b0;
   int   last_delay;
   int   last_acc;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
      end
   endtask

   // latency in cycles from acceptance to done, counting the acceptance cycle as 1
   function automatic int latency(input int o, input int n);
      int d;
      d = (n > o) ? n - o : o - n;
      if (d == 0) return 1;
`ifdef HYPERBUS_DELAY_RAMP_EN
      return (S + 1) * (d + 1) + 1;
`else
      return 2 * S + 3;
`endif
   endfunction

   // delay code the line should carry in the cycle following posedge number c
   function automatic int exp_delay(input int c);
      int p, d, steps;
      p = c - win_acc;
      if (p < S + 1) return win_old;
`ifdef HYPERBUS_DELAY_RAMP_EN
      d = (win_new > win_old) ? win_new - win_old : win_old - win_new;
      steps = (p - (S + 1)) / (S + 1) + 1;
      if (steps > d) steps = d;
      return (win_new > win_old) ? win_old + steps : win_old - steps;
`else
      d = 0;
      steps = 0;
      return win_new + d + steps;
`endif
   endfunction

   // per-cycle monitor and done_o scoreboard
   always @(negedge clk) begin
      int   p;
      bit   exp_busy, exp_gate;
      exp_t e;
      if (mon_en) begin
         p        = cyc - win_acc;
         exp_busy = win_chg && (p >= 0) && (p <= win_len - 2);
         exp_gate = win_chg && (p >= 0) && (p <= win_len - 3);
         chk("ready", int'(req_ready), int'(!exp_busy));
         chk("busy", int'(busy), int'(exp_busy));
         chk("enable", int'(enable), int'(phy_en & !exp_gate));
         chk("delay", int'(delay), exp_delay(cyc));
         if (int'(delay) != last_delay)
            chk("gated_change", int'({busy, enable}), 2);
         last_delay = int'(delay);
         if (done) begin
            if (q.size() == 0) begin
               chk("done_spurious", int'(done), 0);
            end else begin
               e = q.pop_front();
               chk("done_code", int'(delay), e.code);
               chk("done_cycle", cyc, e.due);
            end
         end else if (q.size() != 0 && cyc > q[0].due) begin
            chk("done_timeout", int'(done), 1);
            void'(q.pop_front());
         end
      end
   end

   // present a code, hold it until accepted, then record the expectation
   task automatic send(input int code, input bit junk);
      int waited;
      int acc, a_code, l;
      exp_t e;
      waited    = 0;
      req_valid = 1'b1;
      req_delay = DW'(code);
      while (1) begin
         if (req_ready) break;
         if (waited >= 300) begin
            chk("accept_timeout", int'(req_ready), 1);
            req_valid = 1'b0;
            return;
         end
         if (junk) req_delay = DW'($urandom_range(0, 15));
         @(negedge clk);
         #1;
         if (phy_rand) phy_en = ($urandom_range(0, 3) != 0);
         waited++;
      end
      acc     = cyc + 1;
      a_code  = int'(req_delay);
      l       = latency(cur, a_code);
      win_acc = acc;
      win_old = cur;
      win_new = a_code;
      win_chg = (a_code != cur);
      win_len = l;
      e.code  = a_code;
      e.due   = acc + l - 1;
      q.push_back(e);
      cur      = a_code;
      last_acc = acc;
      @(negedge clk);
      #1;
      req_valid = 1'b0;
   endtask

   task automatic model_reset();
      q.delete();
      cur        = RD;
      win_acc    = 0;
      win_old    = RD;
      win_new    = RD;
      win_chg    = 1'b0;
      win_len    = 1;
      last_delay = RD;
   endtask

   initial begin
      int w;
      rst_n     = 1'b0;
      phy_en    = 1'b1;
      req_valid = 1'b0;
      req_delay = '0;
      model_reset();
      #1;
      chk("rst_delay", int'(delay), RD);
      chk("rst_enable", int'(enable), 1);
      chk("rst_ready", int'(req_ready), 1);
      chk("rst_done", int'(done), 0);
      chk("rst_busy", int'(busy), 0);
      repeat (3) @(negedge clk);
      #1;
      rst_n  = 1'b1;
      mon_en = 1'b1;

      // equal code, then a change, then a code held off while busy
      send(0, 1'b0);
      send(9, 1'b0);
      send(3, 1'b0);

      // asynchronous reset while settling after 9 is applied
      send(9, 1'b0);
      w = 0;
      while (cyc < last_acc + S + 2 && w < 200) begin
         @(negedge clk);
         w++;
      end
      chk("pre_reset_delay", int'(delay), 9);
      mon_en = 1'b0;
      #2;
      phy_en = 1'b1;
      rst_n  = 1'b0;
      #1;
      chk("midrst_delay", int'(delay), RD);
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_enable", int'(enable), int'(phy_en));
      chk("midrst_ready", int'(req_ready), 1);
      model_reset();
      @(negedge clk);
      #1;
      rst_n  = 1'b1;
      mon_en = 1'b1;

      // randomized traffic with PHY enable toggling and code changes while held off
      phy_rand = 1'b1;
      for (int i = 0; i < 30; i++) begin
         int gap, code;
         gap  = $urandom_range(0, 3);
         for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            #1;
            phy_en = ($urandom_range(0, 3) != 0);
         end
         code = ($urandom_range(0, 3) == 0) ? cur : int'($urandom_range(0, 15));
         send(code, bit'($urandom_range(0, 1)));
      end

      w = 0;
      while (q.size() != 0 && w < 200) begin
         @(negedge clk);
         w++;
      end
      chk("queue_drained", q.size(), 0);
      mon_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
